// File: rtl/vx_gpr_bank_arbiter.sv
// Per-cycle scheduler for the single-ported banked GPR file: write beats reads per bank,
// reads round-robin per bank, 3-cycle read return. GPR_ARB_STARVE_EN adds a read anti-starvation override.
`ifndef NUM_GPR_BANKS
`define NUM_GPR_BANKS 4
`endif

module vx_gpr_bank_arbiter #(
  parameter int NUM_BANKS    = `NUM_GPR_BANKS,
  parameter int NUM_RD_REQS  = 4,
  parameter int SET_W        = 6,
  parameter int DATA_W       = 128,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int BANK_W      = $clog2(NUM_BANKS),
  localparam int BE_W        = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_RD_REQS-1:0]        rd_req_valid,
  input  logic [NUM_RD_REQS*BANK_W-1:0] rd_req_bank,
  input  logic [NUM_RD_REQS*SET_W-1:0]  rd_req_set,
  input  logic [NUM_RD_REQS*TAG_W-1:0]  rd_req_tag,
  output logic [NUM_RD_REQS-1:0]        rd_req_ready,
  input  logic                          wr_req_valid,
  input  logic [BANK_W-1:0]             wr_req_bank,
  input  logic [SET_W-1:0]              wr_req_set,
  input  logic [DATA_W-1:0]             wr_req_data,
  input  logic [BE_W-1:0]               wr_req_byteen,
  output logic                          wr_req_ready,
  output logic [NUM_BANKS-1:0]          bank_read_en,
  output logic [NUM_BANKS*SET_W-1:0]    bank_rd_set,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_rd_data,
  output logic [NUM_BANKS-1:0]          bank_write_en,
  output logic [NUM_BANKS*SET_W-1:0]    bank_wr_set,
  output logic [NUM_BANKS*DATA_W-1:0]   bank_wr_data,
  output logic [NUM_BANKS*BE_W-1:0]     bank_wr_byteen,
  output logic [NUM_RD_REQS-1:0]        rd_rsp_valid,
  output logic [NUM_RD_REQS*DATA_W-1:0] rd_rsp_data,
  output logic [NUM_RD_REQS*TAG_W-1:0]  rd_rsp_tag
);
  localparam int RR_W = (NUM_RD_REQS > 1) ? $clog2(NUM_RD_REQS) : 1;

  logic [NUM_RD_REQS-1:0][BANK_W-1:0] rd_bank;
  logic [NUM_RD_REQS-1:0][SET_W-1:0]  rd_set;
  logic [NUM_RD_REQS-1:0][TAG_W-1:0]  rd_tag;
  logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_dat;

  assign rd_bank  = rd_req_bank;
  assign rd_set   = rd_req_set;
  assign rd_tag   = rd_req_tag;
  assign bank_dat = bank_rd_data;

  logic [NUM_BANKS-1:0]           rd_any, rd_gnt, wr_hit, wr_gnt, ovr;
  logic [NUM_BANKS-1:0][RR_W-1:0] gnt_idx, ptr_d, ptr_q;
  logic [NUM_RD_REQS-1:0]         rd_rdy;
  logic                           found;
  int                             idx;

  always_comb begin
    rd_any  = '0;
    rd_gnt  = '0;
    gnt_idx = '0;
    wr_hit  = '0;
    wr_gnt  = '0;
    rd_rdy  = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_hit[b] = wr_req_valid && (wr_req_bank == BANK_W'(b));
      for (int i = 0; i < NUM_RD_REQS; i++)
        if (rd_req_valid[i] && (rd_bank[i] == BANK_W'(b))) rd_any[b] = 1'b1;
      // A pending write keeps the bank unless the starvation override has fired.
      if (reset_n && rd_any[b] && !(wr_hit[b] && !ovr[b])) begin
        found = 1'b0;
        for (int k = 0; k < NUM_RD_REQS; k++) begin
          idx = (int'(ptr_q[b]) + k) % NUM_RD_REQS;
          if (!found && rd_req_valid[idx] && (rd_bank[idx] == BANK_W'(b))) begin
            found      = 1'b1;
            gnt_idx[b] = RR_W'(idx);
            rd_rdy[idx] = 1'b1;
          end
        end
        rd_gnt[b] = 1'b1;
        ptr_d[b]  = RR_W'((int'(gnt_idx[b]) + 1) % NUM_RD_REQS);
      end
      wr_gnt[b] = reset_n && wr_hit[b] && !rd_gnt[b];
    end
  end

  assign rd_req_ready = rd_rdy;
  assign wr_req_ready = reset_n && wr_req_valid && !(ovr[wr_req_bank] && rd_any[wr_req_bank]);

`ifdef GPR_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [NUM_BANKS-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    ovr = '0;
    for (int b = 0; b < NUM_BANKS; b++) ovr[b] = (cnt_q[b] == CNT_W'(STARVE_LIMIT));
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_gnt[b]) cnt_d[b] = '0;
      else if (rd_any[b] && wr_gnt[b] && (cnt_q[b] != CNT_W'(STARVE_LIMIT)))
        cnt_d[b] = cnt_q[b] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign ovr = '0;
`endif

  logic [NUM_BANKS-1:0]              ren_d, ren_q, wen_d, wen_q;
  logic [NUM_BANKS-1:0][SET_W-1:0]   rset_d, rset_q, wset_d, wset_q;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  wdat_d, wdat_q;
  logic [NUM_BANKS-1:0][BE_W-1:0]    wbe_d, wbe_q;
  logic [NUM_BANKS-1:0]              s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q;
  logic [NUM_BANKS-1:0][RR_W-1:0]    s1_req_d, s1_req_q, s2_req_d, s2_req_q;
  logic [NUM_BANKS-1:0][TAG_W-1:0]   s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q;
  logic [NUM_RD_REQS-1:0]            rsp_vld_d, rsp_vld_q;
  logic [NUM_RD_REQS-1:0][DATA_W-1:0] rsp_dat_d, rsp_dat_q;
  logic [NUM_RD_REQS-1:0][TAG_W-1:0]  rsp_tag_d, rsp_tag_q;

  always_comb begin
    ren_d     = rd_gnt;
    wen_d     = wr_gnt;
    rset_d    = rset_q;
    wset_d    = wset_q;
    wdat_d    = wdat_q;
    wbe_d     = wbe_q;
    s1_vld_d  = rd_gnt;
    s1_req_d  = gnt_idx;
    s1_tag_d  = '0;
    s2_vld_d  = s1_vld_q;
    s2_req_d  = s1_req_q;
    s2_tag_d  = s1_tag_q;
    rsp_vld_d = '0;
    rsp_dat_d = rsp_dat_q;
    rsp_tag_d = rsp_tag_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_gnt[b]) begin
        rset_d[b]   = rd_set[gnt_idx[b]];
        s1_tag_d[b] = rd_tag[gnt_idx[b]];
      end
      if (wr_gnt[b]) begin
        wset_d[b] = wr_req_set;
        wdat_d[b] = wr_req_data;
        wbe_d[b]  = wr_req_byteen;
      end
      // Data stage: the bank's output belongs to whoever was granted two cycles ago.
      if (s2_vld_q[b]) begin
        rsp_vld_d[s2_req_q[b]] = 1'b1;
        rsp_dat_d[s2_req_q[b]] = bank_dat[b];
        rsp_tag_d[s2_req_q[b]] = s2_tag_q[b];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0; ren_q <= '0; wen_q <= '0; rset_q <= '0; wset_q <= '0;
      wdat_q <= '0; wbe_q <= '0;
      s1_vld_q <= '0; s1_req_q <= '0; s1_tag_q <= '0;
      s2_vld_q <= '0; s2_req_q <= '0; s2_tag_q <= '0;
      rsp_vld_q <= '0; rsp_dat_q <= '0; rsp_tag_q <= '0;
    end else begin
      ptr_q <= ptr_d; ren_q <= ren_d; wen_q <= wen_d; rset_q <= rset_d; wset_q <= wset_d;
      wdat_q <= wdat_d; wbe_q <= wbe_d;
      s1_vld_q <= s1_vld_d; s1_req_q <= s1_req_d; s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d; s2_req_q <= s2_req_d; s2_tag_q <= s2_tag_d;
      rsp_vld_q <= rsp_vld_d; rsp_dat_q <= rsp_dat_d; rsp_tag_q <= rsp_tag_d;
    end
  end

  assign bank_read_en   = ren_q;
  assign bank_rd_set    = rset_q;
  assign bank_write_en  = wen_q;
  assign bank_wr_set    = wset_q;
  assign bank_wr_data   = wdat_q;
  assign bank_wr_byteen = wbe_q;
  assign rd_rsp_valid   = rsp_vld_q;
  assign rd_rsp_data    = rsp_dat_q;
  assign rd_rsp_tag     = rsp_tag_q;
endmodule

// File: tb/tb_vx_gpr_bank_arbiter.sv
// Directed bench for vx_gpr_bank_arbiter: grant table plus multi-cycle read/reset/starvation sequences.
module tb_vx_gpr_bank_arbiter;
  localparam int NB = 4, NR = 4, SW = 6, DW = 128, TW = 4, BW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    rd_req_valid;
  logic [NR*BW-1:0] rd_req_bank;
  logic [NR*SW-1:0] rd_req_set;
  logic [NR*TW-1:0] rd_req_tag;
  logic [NR-1:0]    rd_req_ready;
  logic             wr_req_valid;
  logic [BW-1:0]    wr_req_bank;
  logic [SW-1:0]    wr_req_set;
  logic [DW-1:0]    wr_req_data;
  logic [DW/8-1:0]  wr_req_byteen;
  logic             wr_req_ready;
  logic [NB-1:0]    bank_read_en;
  logic [NB*SW-1:0] bank_rd_set;
  logic [NB*DW-1:0] bank_rd_data;
  logic [NB-1:0]    bank_write_en;
  logic [NB*SW-1:0] bank_wr_set;
  logic [NB*DW-1:0] bank_wr_data;
  logic [NB*DW/8-1:0] bank_wr_byteen;
  logic [NR-1:0]    rd_rsp_valid;
  logic [NR*DW-1:0] rd_rsp_data;
  logic [NR*TW-1:0] rd_rsp_tag;

  vx_gpr_bank_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_bank(rd_req_bank), .rd_req_set(rd_req_set),
    .rd_req_tag(rd_req_tag), .rd_req_ready(rd_req_ready),
    .wr_req_valid(wr_req_valid), .wr_req_bank(wr_req_bank), .wr_req_set(wr_req_set),
    .wr_req_data(wr_req_data), .wr_req_byteen(wr_req_byteen), .wr_req_ready(wr_req_ready),
    .bank_read_en(bank_read_en), .bank_rd_set(bank_rd_set), .bank_rd_data(bank_rd_data),
    .bank_write_en(bank_write_en), .bank_wr_set(bank_wr_set), .bank_wr_data(bank_wr_data),
    .bank_wr_byteen(bank_wr_byteen), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_tag(rd_rsp_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] rd_vld;
    logic [7:0] rd_bank;
    logic       wr_vld;
    logic [1:0] wr_bank;
    logic [3:0] exp_rd_rdy;
    logic       exp_wr_rdy;
    logic [3:0] exp_ren;
    logic [3:0] exp_wen;
  } vec_t;

  vec_t vec [10];

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; rd_req_valid = '0; wr_req_valid = 1'b0; bank_rd_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] seen;
    logic          exp_rd;
    int            g;
    vec[0] = '{4'b0000, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vec[1] = '{4'b1110, 8'hE4, 1'b1, 2'd0, 4'b1110, 1'b1, 4'b1110, 4'b0001};
    vec[2] = '{4'b0001, 8'h03, 1'b1, 2'd3, 4'b0000, 1'b1, 4'b0000, 4'b1000};
    vec[3] = '{4'b0001, 8'h03, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b1000, 4'b0000};
    vec[4] = '{4'b0011, 8'h05, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0010, 4'b0000};
    vec[5] = '{4'b0011, 8'h05, 1'b0, 2'd0, 4'b0010, 1'b0, 4'b0010, 4'b0000};
    vec[6] = '{4'b1111, 8'hAA, 1'b0, 2'd0, 4'b1000, 1'b0, 4'b0100, 4'b0000};
    vec[7] = '{4'b0010, 8'h00, 1'b1, 2'd2, 4'b0010, 1'b1, 4'b0001, 4'b0100};
    vec[8] = '{4'b1100, 8'h90, 1'b1, 2'd1, 4'b1000, 1'b1, 4'b0100, 4'b0010};
    vec[9] = '{4'b0011, 8'h00, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 4'b0000};

    // Reset held with every requester valid
    reset_n = 1'b0;
    rd_req_valid = 4'hF; rd_req_bank = 8'hE4; rd_req_set = {6'd3, 6'd2, 6'd1, 6'd0};
    rd_req_tag = {4'd3, 4'd2, 4'd1, 4'd0};
    wr_req_valid = 1'b1; wr_req_bank = 2'd0; wr_req_set = 6'd9;
    wr_req_data = {4{32'h1234_5678}}; wr_req_byteen = 16'hFFFF; bank_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rd_ready", 128'(rd_req_ready), 128'(0));
    check("rst_wr_ready", 128'(wr_req_ready), 128'(0));
    @(posedge clk); #1;
    check("rst_read_en", 128'(bank_read_en), 128'(0));
    check("rst_write_en", 128'(bank_write_en), 128'(0));
    check("rst_rd_set", 128'(bank_rd_set), 128'(0));
    check("rst_wr_data", bank_wr_data[127:0], 128'(0));
    check("rst_rsp_valid", 128'(rd_rsp_valid), 128'(0));
    @(negedge clk); reset_n = 1'b1; #1;
    check("rel_rd_ready", 128'(rd_req_ready), 128'(4'b1110));
    check("rel_wr_ready", 128'(wr_req_ready), 128'(1));
    @(posedge clk); #1;
    check("rel_read_en", 128'(bank_read_en), 128'(4'b1110));
    check("rel_write_en", 128'(bank_write_en), 128'(4'b0001));
    check("rel_wr_set", 128'(bank_wr_set[5:0]), 128'(9));

    // Grant table from fresh pointers
    do_reset();
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      rd_req_valid = vec[v].rd_vld; rd_req_bank = vec[v].rd_bank;
      wr_req_valid = vec[v].wr_vld; wr_req_bank = vec[v].wr_bank;
      #1;
      check($sformatf("vec%0d_rd_ready", v), 128'(rd_req_ready), 128'(vec[v].exp_rd_rdy));
      check($sformatf("vec%0d_wr_ready", v), 128'(wr_req_ready), 128'(vec[v].exp_wr_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_read_en", v), 128'(bank_read_en), 128'(vec[v].exp_ren));
      check($sformatf("vec%0d_write_en", v), 128'(bank_write_en), 128'(vec[v].exp_wen));
    end

    // Single read: requester 2, bank 1, set 5, tag A
    do_reset();
    @(negedge clk);
    rd_req_valid = 4'b0100; rd_req_bank = 8'b00_01_00_00;
    rd_req_set = '0; rd_req_set[12 +: 6] = 6'd5;
    rd_req_tag = '0; rd_req_tag[8 +: 4] = 4'hA;
    #1 check("single_ready", 128'(rd_req_ready), 128'(4'b0100));
    @(posedge clk); #1;
    check("single_read_en_n1", 128'(bank_read_en), 128'(4'b0010));
    check("single_rd_set", 128'(bank_rd_set[6 +: 6]), 128'(5));
    @(negedge clk); rd_req_valid = '0;
    @(posedge clk); #1;
    check("single_read_en_n2", 128'(bank_read_en), 128'(0));
    bank_rd_data[128 +: 128] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    @(posedge clk); #1;
    check("single_rsp_valid", 128'(rd_rsp_valid), 128'(4'b0100));
    check("single_rsp_tag", 128'(rd_rsp_tag[8 +: 4]), 128'(4'hA));
    check("single_rsp_data", rd_rsp_data[256 +: 128], 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    bank_rd_data = '0;
    @(posedge clk); #1;
    check("single_rsp_pulse", 128'(rd_rsp_valid), 128'(0));
    check("single_rsp_hold", rd_rsp_data[256 +: 128], 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);

    // Round-robin: all four requesters hammer bank 0
    do_reset();
    rd_req_tag = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_req_valid = (c < 5) ? 4'hF : 4'h0; rd_req_bank = '0;
      bank_rd_data = '0; bank_rd_data[127:0] = 128'(c) + 128'h100;
      #1;
      if (c < 5) check($sformatf("rr_grant%0d", c), 128'(rd_req_ready), 128'(1) << (c % 4));
      @(posedge clk); #1;
      if (c >= 2 && c <= 6) begin
        g = c - 2;
        check($sformatf("rr_rsp_valid%0d", g), 128'(rd_rsp_valid), 128'(1) << (g % 4));
        check($sformatf("rr_rsp_tag%0d", g), 128'(rd_rsp_tag[(g % 4) * 4 +: 4]), 128'(g % 4));
        check($sformatf("rr_rsp_data%0d", g), rd_rsp_data[(g % 4) * 128 +: 128], 128'(c) + 128'h100);
      end else begin
        check($sformatf("rr_rsp_idle%0d", c), 128'(rd_rsp_valid), 128'(0));
      end
    end

    // Write vs read contending for bank 3
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rd_req_valid = 4'b0001; rd_req_bank = 8'h03;
      wr_req_valid = 1'b1; wr_req_bank = 2'd3;
`ifdef GPR_ARB_STARVE_EN
      exp_rd = (c == 3);
`else
      exp_rd = 1'b0;
`endif
      #1;
      check($sformatf("starve_rd_ready%0d", c), 128'(rd_req_ready), 128'(exp_rd));
      check($sformatf("starve_wr_ready%0d", c), 128'(wr_req_ready), 128'(!exp_rd));
      @(posedge clk); #1;
      check($sformatf("starve_read_en%0d", c), 128'(bank_read_en), exp_rd ? 128'(4'b1000) : 128'(0));
      check($sformatf("starve_write_en%0d", c), 128'(bank_write_en), exp_rd ? 128'(0) : 128'(4'b1000));
    end

    // Reset while a read is in flight
    do_reset();
    @(negedge clk);
    rd_req_valid = 4'b0010; rd_req_bank = 8'b00_00_10_00;
    #1 check("midrst_ready", 128'(rd_req_ready), 128'(4'b0010));
    @(negedge clk);
    rd_req_valid = '0; reset_n = 1'b0; bank_rd_data = '1;
    #1 check("midrst_read_en", 128'(bank_read_en), 128'(0));
    @(negedge clk); reset_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | rd_rsp_valid;
    end
    check("midrst_no_rsp", 128'(seen), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
